wb_write_sequencer: RTL and testbench
=====================================

// Module: wb_write_sequencer
// PURPOSE
//  Owns the single 32-bit integer register-file write port behind the writeback stage.
//  Arbitrates between the pipeline writeback requester (WB, may carry a 64-bit LDD pair)
//  and an auxiliary late-result requester (AUX: multi-cycle mul/div, trap unit).
//  Splits doubleword writes into two sequential even/odd register writes and stalls WB meanwhile.
// PARAMETERS
//  DATA_W        32  register-file write-port width; WB double data is 2*DATA_W
//  REG_AW        5   register address width
//  STARVE_LIMIT  4   consecutive cycles AUX may be denied before it is forced a slot (>=1)
// PORTS
//  clk          in   1         clock, rising edge
//  reset        in   1         asynchronous, active-high
//  wb_valid     in   1         WB write request present
//  wb_ready     out  1         WB request accepted this cycle
//  wb_regD      in   REG_AW    WB destination register
//  wb_double    in   1         WB request is a register pair (LDD-type)
//  wb_data      in   2*DATA_W  WB data; single write uses [DATA_W-1:0]
//  aux_valid    in   1         AUX write request present
//  aux_ready    out  1         AUX request accepted this cycle
//  aux_regD     in   REG_AW    AUX destination register
//  aux_data     in   DATA_W    AUX data
//  rf_we        out  1         register-file write enable (registered)
//  rf_waddr     out  REG_AW    register-file write address (registered)
//  rf_wdata     out  DATA_W    register-file write data (registered)
//  wb_stall     out  1         = wb_valid & ~wb_ready; holds upstream pipeline
//  busy         out  1         FSM in SECOND
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE, starve_cnt->0, hold regs->0, rf_we/rf_waddr/rf_wdata->0.
//   wb_ready/aux_ready/wb_stall/busy are combinational; all 0 while reset high (wb_stall=0 too).
//  FSM states: IDLE, SECOND.
//  IDLE grant (combinational, at most one ready per cycle):
//   - aux_valid & starve_cnt==STARVE_LIMIT -> AUX granted (forced), even if wb_valid.
//   - else wb_valid -> WB granted.  - else aux_valid -> AUX granted.
//  starve_cnt: +1 each cycle aux_valid & ~aux_ready (saturates at STARVE_LIMIT); ->0 on AUX
//   grant or when aux_valid low.
//  Latency: grant in cycle N -> rf_we/rf_waddr/rf_wdata valid in cycle N+1 (one register stage).
//  WB single granted: next rf_waddr=wb_regD, rf_wdata=wb_data[DATA_W-1:0]; stay IDLE.
//  WB double granted: next rf_waddr={wb_regD[REG_AW-1:1],1'b0}, rf_wdata=wb_data[2*DATA_W-1:DATA_W]
//   (even reg gets high word); capture odd addr {..,1'b1} and wb_data[DATA_W-1:0]; ->SECOND.
//   Odd wb_regD is forced even (bit0 ignored).
//  SECOND: wb_ready=aux_ready=0 (wb_stall follows wb_valid); next rf output = captured odd
//   write; ->IDLE. starve_cnt still counts. No back-to-back gap: IDLE grant allowed next cycle.
//  AUX granted: next rf_waddr=aux_regD, rf_wdata=aux_data.
//  r0 rule: any write whose address is 0 consumes its slot but drives rf_we=0 (addr/data still
//   driven). Double to r0: first half suppressed, r1 write still performed.
//  No grant (idle/SECOND excluded): rf_we=0; rf_waddr/rf_wdata hold previous values.
//  Requesters must hold valid and payload stable until ready; payload sampled only on ready.
//  Reset during SECOND: pending odd write is dropped, never issued.
// TESTING
//  1. WB single r5=0x1234_5678, aux idle -> wb_ready same cycle; next cycle rf_we=1, addr 5, data 0x12345678.
//  2. WB double regD=8, data=0xAAAA_0001_BBBB_0002 -> r8=0xAAAA0001 then r9=0xBBBB0002 on consecutive
//     cycles; wb_stall=1 for one cycle if next WB request queued; busy=1 in SECOND.
//  3. wb_valid and aux_valid held continuously -> AUX granted on 5th cycle (STARVE_LIMIT=4 denials),
//     WB stalled that cycle, counter then 0 and pattern repeats.
//  4. WB single to r0 and double to r0 -> no rf_we for r0; double still writes r1 with low word.
//  5. Double regD=8 then reset asserted in SECOND -> all outputs 0 immediately; r9 never written.
//  6. AUX request arrives during SECOND -> aux_ready=0 that cycle, granted next IDLE cycle if no
//     higher rule applies; starve_cnt increments by 1 during the wait.

Source files
------------

// File: rtl/wb_write_sequencer.sv
// Register-file write-port sequencer behind writeback.
// Arbitrates WB and AUX writers, splits LDD pairs into two writes.
module wb_write_sequencer #(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [REG_AW-1:0]   wb_regD,
  input  logic                wb_double,
  input  logic [2*DATA_W-1:0] wb_data,
  input  logic                aux_valid,
  output logic                aux_ready,
  input  logic [REG_AW-1:0]   aux_regD,
  input  logic [DATA_W-1:0]   aux_data,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                wb_stall,
  output logic                busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]        state;
  logic [CW-1:0]     starve_cnt;
  logic [REG_AW-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              idle;
  logic              force_aux;
  logic [REG_AW-1:0] even_addr;

  // Grant logic: a starved AUX beats WB, otherwise WB first.
  always_comb begin
    idle      = ~reset & (state == IDLE);
    force_aux = aux_valid & (starve_cnt == LIMIT);
    aux_ready = idle & aux_valid & (force_aux | ~wb_valid);
    wb_ready  = idle & wb_valid & ~force_aux;
    wb_stall  = ~reset & wb_valid & ~wb_ready;
    busy      = ~reset & (state == SECOND);
    even_addr = {wb_regD[REG_AW-1:1], 1'b0};
  end

  // Count consecutive AUX denials, saturating at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!aux_valid || aux_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Issue one register write per slot; r0 writes keep we low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      rf_we <= 1'b0;
      unique case (1'b1)
        (state == SECOND): begin
          rf_we    <= |hold_addr;
          rf_waddr <= hold_addr;
          rf_wdata <= hold_data;
          state    <= IDLE;
        end
        wb_ready: begin
          if (wb_double) begin
            rf_we     <= |even_addr;
            rf_waddr  <= even_addr;
            rf_wdata  <= wb_data[2*DATA_W-1:DATA_W];
            hold_addr <= {wb_regD[REG_AW-1:1], 1'b1};
            hold_data <= wb_data[DATA_W-1:0];
            state     <= SECOND;
          end else begin
            rf_we    <= |wb_regD;
            rf_waddr <= wb_regD;
            rf_wdata <= wb_data[DATA_W-1:0];
          end
        end
        aux_ready: begin
          rf_we    <= |aux_regD;
          rf_waddr <= aux_regD;
          rf_wdata <= aux_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer.
// Expected writes queued at grant time, checked by a monitor.
module tb_wb_write_sequencer;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_regD = '0;
  logic        wb_double = 1'b0;
  logic [63:0] wb_data = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_regD = '0;
  logic [31:0] aux_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        busy;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  wr_t q[$];

  wb_write_sequencer dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_regD(wb_regD), .wb_double(wb_double),
    .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_regD(aux_regD), .aux_data(aux_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n,
                              logic [63:0] act,
                              logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endfunction

  // expected write appears off cycles after the current grant cycle
  task automatic exp(input int off,
                     input logic [4:0] a,
                     input logic [31:0] d);
    wr_t e;
    e.cyc = cyc + off;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic step(input logic ew, input logic ea);
    #1;
    chk("wb_ready", wb_ready, ew);
    chk("aux_ready", aux_ready, ea);
    chk("wb_stall", wb_stall, wb_valid & ~ew);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every visible write must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_write got=none exp=r%0d",
                 q[0].a);
        void'(q.pop_front());
      end
      if (rf_we) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got=r%0d exp=none",
                   rf_waddr);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_cyc", 64'(cyc), 64'(e.cyc));
          chk("wr_addr", rf_waddr, e.a);
          chk("wr_data", rf_wdata, e.d);
        end
      end
    end
  end

  task automatic idle(input int n);
    wb_valid = 1'b0;
    aux_valid = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    wb_valid = 1'b1;
    aux_valid = 1'b1;
    #2;
    chk("rst_wb_ready", wb_ready, 0);
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_waddr, 0);
    chk("rst_data", rf_wdata, 0);
    wb_valid = 1'b0;
    aux_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single WB write
    wb_valid = 1'b1;
    wb_double = 1'b0;
    wb_regD = 5'd5;
    wb_data = 64'h0000_0000_1234_5678;
    exp(1, 5'd5, 32'h1234_5678);
    step(1'b1, 1'b0);
    idle(2);

    // double with a queued WB behind it
    wb_valid = 1'b1;
    wb_double = 1'b1;
    wb_regD = 5'd8;
    wb_data = 64'hAAAA_0001_BBBB_0002;
    exp(1, 5'd8, 32'hAAAA_0001);
    exp(2, 5'd9, 32'hBBBB_0002);
    step(1'b1, 1'b0);
    wb_double = 1'b0;
    wb_regD = 5'd3;
    wb_data = 64'h0000_0000_0000_0033;
    chk("busy_second", busy, 1);
    exp(2, 5'd3, 32'h0000_0033);
    step(1'b0, 1'b0);
    chk("busy_after", busy, 0);
    step(1'b1, 1'b0);
    idle(2);

    // odd destination on a double is forced even
    wb_valid = 1'b1;
    wb_double = 1'b1;
    wb_regD = 5'd13;
    wb_data = 64'h1111_2222_3333_4444;
    exp(1, 5'd12, 32'h1111_2222);
    exp(2, 5'd13, 32'h3333_4444);
    step(1'b1, 1'b0);
    idle(3);

    // starvation: AUX forced after four denials
    wb_valid = 1'b1;
    wb_double = 1'b0;
    aux_valid = 1'b1;
    aux_regD = 5'd2;
    aux_data = 32'hA000_0002;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        exp(1, aux_regD, aux_data);
        step(1'b0, 1'b1);
        aux_regD = aux_regD + 5'd1;
        aux_data = aux_data + 32'd1;
      end else begin
        wb_regD = 5'(16 + i);
        wb_data = 64'(32'hB000_0000 + i);
        exp(1, wb_regD, wb_data[31:0]);
        step(1'b1, 1'b0);
      end
    end
    idle(2);

    // r0 suppression
    wb_valid = 1'b1;
    wb_double = 1'b0;
    wb_regD = 5'd0;
    wb_data = 64'h0000_0000_DEAD_BEEF;
    step(1'b1, 1'b0);
    wb_double = 1'b1;
    wb_data = 64'hCCCC_0003_DDDD_0004;
    exp(2, 5'd1, 32'hDDDD_0004);
    step(1'b1, 1'b0);
    wb_valid = 1'b0;
    step(1'b0, 1'b0);
    idle(2);

    // AUX arriving during SECOND waits one cycle
    wb_valid = 1'b1;
    wb_double = 1'b1;
    wb_regD = 5'd20;
    wb_data = 64'h5555_0020_6666_0021;
    exp(1, 5'd20, 32'h5555_0020);
    exp(2, 5'd21, 32'h6666_0021);
    step(1'b1, 1'b0);
    wb_valid = 1'b0;
    aux_valid = 1'b1;
    aux_regD = 5'd7;
    aux_data = 32'h7777_0007;
    step(1'b0, 1'b0);
    exp(1, 5'd7, 32'h7777_0007);
    step(1'b0, 1'b1);
    idle(2);

    // reset in SECOND drops the odd half
    wb_valid = 1'b1;
    wb_double = 1'b1;
    wb_regD = 5'd8;
    wb_data = 64'hAAAA_0001_BBBB_0002;
    step(1'b1, 1'b0);
    chk("r5_we", rf_we, 1);
    chk("r5_addr", rf_waddr, 5'd8);
    chk("r5_data", rf_wdata, 32'hAAAA_0001);
    chk("r5_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("r5_rst_we", rf_we, 0);
    chk("r5_rst_addr", rf_waddr, 0);
    chk("r5_rst_data", rf_wdata, 0);
    chk("r5_rst_busy", busy, 0);
    chk("r5_rst_ready", wb_ready, 0);
    chk("r5_rst_stall", wb_stall, 0);
    wb_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    chk("r5_busy_post", busy, 0);

    chk("queue_empty", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
